// File: rtl/mem_dump_reader.sv
// mem_dump_reader: reads a contiguous, wrapping address range out of a word
// memory with a combinational read port and streams each word together with
// its source address over a valid/ready interface.
//
// Ports:
//   clock_i, reset_i          clock (rising edge) and async active-high reset
//   start_i, abort_i          begin a dump (sampled in IDLE) / cancel a dump
//   base_addr_i, count_i      first address and word count, sampled with start
//   mem_addr_o, mem_rd_en_o   memory read address and read strobe
//   mem_rdata_i               combinational read data for mem_addr_o
//   out_valid_o, out_ready_i  stream handshake
//   out_data_o, out_addr_o    captured word and the address it came from
//   out_last_o                marks the final word of a dump
//   busy_o, done_o            engine active / one-cycle completion pulse
//
// Latency: first word valid two edges after start is seen, then one word
// every two cycles while out_ready_i is held high.
// Backpressure: the output word is held stable until accepted; the engine
// does not read ahead.

module mem_dump_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 32
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH:0]   count_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_rd_en_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [ADDR_WIDTH-1:0] out_addr_o,
  output logic                  out_last_o,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_READ   = 2'd1,
    S_SEND   = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  // Word count limit and last valid address, sized to the counters they
  // are compared against.
  localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   ONE_W   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] LAST_A  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE_A   = ADDR_WIDTH'(1);

  state_t                  state_q,     state_d;
  logic [ADDR_WIDTH-1:0]   cur_addr_q,  cur_addr_d;
  logic [ADDR_WIDTH:0]     remain_q,    remain_d;
  logic [DATA_WIDTH-1:0]   out_data_q,  out_data_d;
  logic [ADDR_WIDTH-1:0]   out_addr_q,  out_addr_d;
  logic                    out_last_q,  out_last_d;
  logic                    out_valid_q, out_valid_d;

  logic [ADDR_WIDTH:0]     count_clamped;
  logic [ADDR_WIDTH-1:0]   next_addr;

  // Requests larger than the memory read every word exactly once.
  assign count_clamped = (count_i > DEPTH_W) ? DEPTH_W : count_i;

  // Explicit wrap so a non-power-of-two DEPTH still returns to address 0.
  assign next_addr = (cur_addr_q == LAST_A) ? '0 : (cur_addr_q + ONE_A);

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      cur_addr_q  <= '0;
      remain_q    <= '0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remain_q    <= remain_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remain_d    = remain_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    mem_rd_en_o = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // abort has no meaning here; only start is looked at.
        if (start_i) begin
          cur_addr_d = base_addr_i;
          remain_d   = count_clamped;
          state_d    = (count_clamped == '0) ? S_FINISH : S_READ;
        end
      end

      S_READ: begin
        mem_rd_en_o = 1'b1;
        if (abort_i) begin
          // Nothing is captured; the previous word stays on out_data/out_addr.
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = S_FINISH;
        end else begin
          out_data_d  = mem_rdata_i;
          out_addr_d  = cur_addr_q;
          out_last_d  = (remain_q == ONE_W);
          out_valid_d = 1'b1;
          state_d     = S_SEND;
        end
      end

      S_SEND: begin
        if (abort_i) begin
          // A handshake in this same cycle still counts as delivered at the
          // sink; the engine simply stops afterwards.
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = S_FINISH;
        end else if (out_ready_i) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            out_last_d = 1'b0;
            state_d    = S_FINISH;
          end else begin
            cur_addr_d = next_addr;
            remain_d   = remain_q - ONE_W;
            state_d    = S_READ;
          end
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign mem_addr_o  = cur_addr_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_addr_o  = out_addr_q;
  assign out_last_o  = out_last_q;
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_FINISH);

endmodule

// File: tb/tb_mem_dump_reader.sv
module tb_mem_dump_reader;

  logic        clock;
  logic        reset;
  logic        start;
  logic        abort;
  logic [4:0]  base_addr;
  logic [5:0]  count;
  logic [4:0]  mem_addr;
  logic        mem_rd_en;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_addr;
  logic        out_last;
  logic        busy;
  logic        done;

  logic [31:0] mem [32];
  assign mem_rdata = mem[mem_addr];

  int n_cmp = 0;
  int n_bad = 0;
  int hs_count = 0;

  logic [31:0] got_data [64];
  logic [4:0]  got_addr [64];
  logic        got_last [64];

  mem_dump_reader #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(32)) dut (
    .clock_i     (clock),
    .reset_i     (reset),
    .start_i     (start),
    .abort_i     (abort),
    .base_addr_i (base_addr),
    .count_i     (count),
    .mem_addr_o  (mem_addr),
    .mem_rd_en_o (mem_rd_en),
    .mem_rdata_i (mem_rdata),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_addr_o  (out_addr),
    .out_last_o  (out_last),
    .busy_o      (busy),
    .done_o      (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Handshakes counted at the edge they complete on.
  always @(posedge clock) begin
    if (!reset && out_valid && out_ready) hs_count = hs_count + 1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start(input logic [4:0] b, input logic [5:0] c);
    base_addr = b;
    count     = c;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // Records every accepted word until done shows up; done_cyc is the number
  // of edges after the start edge at which done is seen (-1 on timeout).
  task automatic collect(input int max_cyc, output int n, output int done_cyc);
    n = 0;
    done_cyc = -1;
    for (int c = 0; c < max_cyc; c++) begin
      if (done) begin
        done_cyc = c;
        break;
      end
      if (out_valid && out_ready && n < 64) begin
        got_data[n] = out_data;
        got_addr[n] = out_addr;
        got_last[n] = out_last;
        n = n + 1;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    n_cmp++; if (mem_addr !== 5'd0)   begin n_bad++; $display("FAIL reset_mem_addr: got %0h want 0", mem_addr); end
    n_cmp++; if (mem_rd_en !== 1'b0)  begin n_bad++; $display("FAIL reset_mem_rd_en: got %0b want 0", mem_rd_en); end
    n_cmp++; if (out_valid !== 1'b0)  begin n_bad++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    n_cmp++; if (out_data !== 32'd0)  begin n_bad++; $display("FAIL reset_out_data: got %0h want 0", out_data); end
    n_cmp++; if (out_addr !== 5'd0)   begin n_bad++; $display("FAIL reset_out_addr: got %0h want 0", out_addr); end
    n_cmp++; if (out_last !== 1'b0)   begin n_bad++; $display("FAIL reset_out_last: got %0b want 0", out_last); end
    n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_cmp++; if (done !== 1'b0)       begin n_bad++; $display("FAIL reset_done: got %0b want 0", done); end
    #2 reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int n, dc;
    out_ready = 1'b1;
    pulse_start(5'd0, 6'd4);
    n_cmp++; if (mem_rd_en !== 1'b1) begin n_bad++; $display("FAIL basic_rd_en_in_read: got %0b want 1", mem_rd_en); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %0b want 1", busy); end
    collect(40, n, dc);
    n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL basic_words: got %0d want 4", n); end
    for (int i = 0; i < 4 && i < n; i++) begin
      n_cmp++; if (got_data[i] !== 32'h100 + i) begin n_bad++; $display("FAIL basic_data[%0d]: got %0h want %0h", i, got_data[i], 32'h100 + i); end
      n_cmp++; if (got_addr[i] !== 5'(i)) begin n_bad++; $display("FAIL basic_addr[%0d]: got %0d want %0d", i, got_addr[i], i); end
      n_cmp++; if (got_last[i] !== (i == 3)) begin n_bad++; $display("FAIL basic_last[%0d]: got %0b want %0b", i, got_last[i], (i == 3)); end
    end
    n_cmp++; if (dc !== 8) begin n_bad++; $display("FAIL basic_done_latency: got %0d want 8", dc); end
    tick();
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL basic_done_width: got done=%0b busy=%0b want 0 0", done, busy); end
  endtask

  task automatic test_backpressure();
    int n, dc;
    out_ready = 1'b0;
    pulse_start(5'd5, 6'd2);
    tick();
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 32'h105 || out_addr !== 5'd5) begin
        n_bad++; $display("FAIL bp_hold[%0d]: got v=%0b d=%0h a=%0d want v=1 d=105 a=5", i, out_valid, out_data, out_addr);
      end
      tick();
    end
    out_ready = 1'b1;
    collect(20, n, dc);
    n_cmp++; if (n !== 2) begin n_bad++; $display("FAIL bp_words: got %0d want 2", n); end
    n_cmp++; if (got_data[0] !== 32'h105 || got_addr[0] !== 5'd5 || got_last[0] !== 1'b0) begin n_bad++; $display("FAIL bp_word0: got %0h@%0d last=%0b want 105@5 last=0", got_data[0], got_addr[0], got_last[0]); end
    n_cmp++; if (got_data[1] !== 32'h106 || got_addr[1] !== 5'd6 || got_last[1] !== 1'b1) begin n_bad++; $display("FAIL bp_word1: got %0h@%0d last=%0b want 106@6 last=1", got_data[1], got_addr[1], got_last[1]); end
    n_cmp++; if (dc < 0) begin n_bad++; $display("FAIL bp_done: got timeout want done pulse"); end
    tick();
  endtask

  task automatic test_wrap();
    int n, dc;
    logic [4:0] ea [4];
    ea[0] = 5'd30; ea[1] = 5'd31; ea[2] = 5'd0; ea[3] = 5'd1;
    out_ready = 1'b1;
    pulse_start(5'd30, 6'd4);
    collect(40, n, dc);
    n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL wrap_words: got %0d want 4", n); end
    for (int i = 0; i < 4 && i < n; i++) begin
      n_cmp++;
      if (got_addr[i] !== ea[i] || got_data[i] !== 32'h100 + 32'(ea[i])) begin
        n_bad++; $display("FAIL wrap_word[%0d]: got %0h@%0d want %0h@%0d", i, got_data[i], got_addr[i], 32'h100 + 32'(ea[i]), ea[i]);
      end
    end
    tick();
  endtask

  task automatic test_clamp();
    int n, dc, lasts;
    out_ready = 1'b1;
    pulse_start(5'd0, 6'd40);
    collect(200, n, dc);
    n_cmp++; if (n !== 32) begin n_bad++; $display("FAIL clamp_words: got %0d want 32", n); end
    lasts = 0;
    for (int i = 0; i < n && i < 64; i++) if (got_last[i] === 1'b1) lasts++;
    n_cmp++; if (lasts !== 1) begin n_bad++; $display("FAIL clamp_last_count: got %0d want 1", lasts); end
    n_cmp++; if (got_addr[31] !== 5'd31 || got_last[31] !== 1'b1 || got_data[31] !== 32'h11F) begin n_bad++; $display("FAIL clamp_final: got %0h@%0d last=%0b want 11f@31 last=1", got_data[31], got_addr[31], got_last[31]); end
    n_cmp++; if (dc !== 64) begin n_bad++; $display("FAIL clamp_done_latency: got %0d want 64", dc); end
    tick();
  endtask

  task automatic test_zero_count();
    int hs0;
    hs0 = hs_count;
    out_ready = 1'b1;
    pulse_start(5'd7, 6'd0);
    n_cmp++; if (busy !== 1'b1 || done !== 1'b1 || out_valid !== 1'b0) begin n_bad++; $display("FAIL zero_finish: got busy=%0b done=%0b valid=%0b want 1 1 0", busy, done, out_valid); end
    tick();
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL zero_idle: got busy=%0b done=%0b want 0 0", busy, done); end
    n_cmp++; if (hs_count !== hs0) begin n_bad++; $display("FAIL zero_no_words: got %0d handshakes want 0", hs_count - hs0); end
  endtask

  task automatic test_abort();
    int hs0;
    hs0 = hs_count;
    out_ready = 1'b1;
    pulse_start(5'd0, 6'd8);
    tick();
    // start during the run must be ignored
    base_addr = 5'd20; count = 6'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    out_ready = 1'b0;
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_addr !== 5'd2 || out_data !== 32'h102) begin n_bad++; $display("FAIL abort_third_word: got v=%0b %0h@%0d want v=1 102@2", out_valid, out_data, out_addr); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || out_last !== 1'b0 || done !== 1'b1) begin n_bad++; $display("FAIL abort_finish: got valid=%0b last=%0b done=%0b want 0 0 1", out_valid, out_last, done); end
    n_cmp++; if (out_data !== 32'h102 || out_addr !== 5'd2) begin n_bad++; $display("FAIL abort_keep_word: got %0h@%0d want 102@2", out_data, out_addr); end
    n_cmp++; if (hs_count - hs0 !== 2) begin n_bad++; $display("FAIL abort_handshakes: got %0d want 2", hs_count - hs0); end
    tick();
    tick();
    tick();
    n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL abort_start_ignored: got busy=%0b valid=%0b done=%0b want 0 0 0", busy, out_valid, done); end
  endtask

  task automatic test_reset_mid_dump();
    int n, dc, hs0;
    hs0 = hs_count;
    out_ready = 1'b0;
    pulse_start(5'd0, 6'd4);
    tick();
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 32'd0 || out_addr !== 5'd0 || out_last !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0 || mem_addr !== 5'd0 || mem_rd_en !== 1'b0) begin
      n_bad++; $display("FAIL midreset_outputs: got v=%0b d=%0h a=%0d l=%0b busy=%0b done=%0b ma=%0d re=%0b want all 0",
                        out_valid, out_data, out_addr, out_last, busy, done, mem_addr, mem_rd_en);
    end
    out_ready = 1'b1;
    tick();
    #3 reset = 1'b0;
    tick();
    n_cmp++; if (hs_count !== hs0 || busy !== 1'b0) begin n_bad++; $display("FAIL midreset_idle: got hs=%0d busy=%0b want 0 0", hs_count - hs0, busy); end
    pulse_start(5'd3, 6'd1);
    collect(20, n, dc);
    n_cmp++; if (n !== 1) begin n_bad++; $display("FAIL midreset_words: got %0d want 1", n); end
    n_cmp++; if (got_data[0] !== 32'h103 || got_addr[0] !== 5'd3 || got_last[0] !== 1'b1) begin n_bad++; $display("FAIL midreset_word: got %0h@%0d last=%0b want 103@3 last=1", got_data[0], got_addr[0], got_last[0]); end
    n_cmp++; if (dc !== 2) begin n_bad++; $display("FAIL midreset_done_latency: got %0d want 2", dc); end
    tick();
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    base_addr = '0;
    count = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h100 + i;
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_clamp();
    test_zero_count();
    test_abort();
    test_reset_mid_dump();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_dump_reader.md
Name: mem_dump_reader

Overview:
- Hardware read-out engine for the CPU's word memories (data memory or register file array). Runs the reverse direction of program loading: it reads a contiguous address range out of a memory and streams each word with its address over a valid/ready interface.
- Sits beside the CPU. Driven by a controller or the testbench after a program run. Consumed by a checker, monitor or trace sink.

Parameters:
- DATA_WIDTH, 32, width of a memory word.
- ADDR_WIDTH, 5, memory address width.
- DEPTH, 32, number of words in the memory. The dump address range is 0..DEPTH-1.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a dump. Sampled only in IDLE.
- abort  in  1  cancels an active dump.
- base_addr  in  ADDR_WIDTH  first address to read. Sampled with start.
- count  in  ADDR_WIDTH+1  number of words to read. Sampled with start.
- mem_addr  out  ADDR_WIDTH  read address to the memory. The memory read is combinational.
- mem_rd_en  out  1  read strobe, for monitoring only.
- mem_rdata  in  DATA_WIDTH  combinational read data for mem_addr.
- out_valid  out  1  stream word available.
- out_ready  in  1  sink accepts the word.
- out_data  out  DATA_WIDTH  captured memory word.
- out_addr  out  ADDR_WIDTH  address the word came from.
- out_last  out  1  high with the final word of a dump.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when a dump completes or is aborted.

Behaviour:
- Reset (asynchronous, active-high):
  - state goes to IDLE.
  - All outputs are 0: mem_addr, mem_rd_en, out_valid, out_data, out_addr, out_last, busy, done.
  - Internal address and remaining counters are cleared.
  - Reset asserted mid-dump discards the in-flight word; no handshake completes.
- States: IDLE, READ, SEND, FINISH.
- IDLE:
  - On start=1, latch cur_addr=base_addr and remain=min(count, DEPTH).
  - If remain==0, go to FINISH; no word is emitted.
  - Otherwise go to READ.
  - abort is ignored in IDLE.
- READ (exactly one cycle):
  - mem_addr=cur_addr and mem_rd_en=1.
  - At the clock edge, out_data<=mem_rdata, out_addr<=cur_addr, out_last<=(remain==1), out_valid<=1, and state goes to SEND.
- SEND:
  - out_data, out_addr, out_last and out_valid are held stable until out_ready=1. out_valid is never dropped without a handshake, except on abort or reset.
  - On handshake (out_valid & out_ready at the edge), out_valid<=0.
  - If out_last, go to FINISH.
  - Otherwise cur_addr<=(cur_addr+1) mod DEPTH, remain<=remain-1, and go to READ.
- FINISH:
  - done=1 for exactly this one cycle, then go to IDLE.
  - busy stays high in FINISH.
- Throughput and latency:
  - One word per 2 cycles when out_ready is held high.
  - First out_valid appears 2 cycles after the start edge (IDLE→READ, READ→SEND).
- Wrap-around:
  - The address increments modulo DEPTH. With base_addr=30 and count=4, addresses are 30, 31, 0, 1.
  - For DEPTH not a power of two, the address wraps explicitly from DEPTH-1 to 0.
- abort in READ or SEND:
  - At the next edge, out_valid<=0 and out_last<=0, and state goes to FINISH, so done pulses.
  - A handshake coinciding with abort counts as accepted.
  - out_data and out_addr keep their last values.
- start while busy is ignored; it is not queued.
- mem_addr holds cur_addr in every state. mem_rd_en is high only in READ.
- Width rules:
  - count is ADDR_WIDTH+1 bits so that DEPTH itself can be requested.
  - Values above DEPTH are clamped to DEPTH.
  - remain is ADDR_WIDTH+1 bits.

Test Plan:
- Basic dump. Preload memory with data[i]=32'h100+i. Apply start with base=0, count=4, out_ready=1. Required: words 0x100–0x103 with out_addr 0–3; out_last only on addr 3; done 1 cycle after the final handshake; 8 cycles from the start edge to done.
- Backpressure. Same preload; base=5, count=2; hold out_ready=0 for 5 cycles on the first word. Required: out_valid stays 1, out_data=0x105 is stable throughout, then 0x106 follows; no word is duplicated or skipped.
- Wrap and clamp:
  - base=30, count=4: addresses 30, 31, 0, 1 with data 0x11E, 0x11F, 0x100, 0x101.
  - base=0, count=40: exactly 32 words, out_last on addr 31.
- Zero count. start with count=0: no out_valid; busy high for one cycle; done pulses one cycle after the start edge.
- Abort and ignored start:
  - base=0, count=8; assert abort while the third word is in SEND with out_ready=0. Required: out_valid drops at the next edge, done pulses, and only 2 handshakes are recorded.
  - A start pulsed during the run is ignored.
- Reset mid-dump. Assert reset asynchronously (not on a clock edge) during SEND. Required: all outputs read 0 immediately, state returns to IDLE, and a new start with base=3, count=1 emits a single 0x103 with out_last=1.
